// File: rtl/uart_tx_csr_sequencer.sv
// uart_tx_csr_sequencer: programs a 16550 over its CSR port, then paces a byte stream into THR on LSR.THRE
module uart_tx_csr_sequencer #(
    parameter logic [15:0] DIVISOR  = 16'd54,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'h07,
    parameter int          TX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [2:0]  csr_addr,
    output logic        csr_write,
    output logic        csr_read,
    output logic [7:0]  csr_wdata,
    input  logic        csr_waitreq,
    input  logic [7:0]  csr_rdata,
    input  logic        csr_rdvalid,
    output logic        init_done,
    output logic [31:0] bytes_sent
);
    typedef enum logic [3:0] {
        RESET_WAIT, W_LCR_DLAB, W_DLL, W_DLM, W_LCR, W_FCR, IDLE, POLL, WAIT_RD, SEND
    } state_t;
    state_t      state;
    logic [2:0]  addr_r;
    logic        wr_r;
    logic        rd_r;
    logic [7:0]  wdata_r;
    logic [4:0]  burst;
    logic        send;
    logic        hs;
    logic        unused_rdata;
    assign unused_rdata = ^{csr_rdata[7:6], csr_rdata[4:0]};
    // SEND streams the producer straight onto the CSR bus; other states use registered commands
    assign send      = state == SEND;
    assign s_ready   = send && !csr_waitreq && burst != 5'd0;
    assign hs        = s_valid && s_ready;
    assign csr_write = send ? s_valid : wr_r;
    assign csr_read  = rd_r;
    assign csr_addr  = send ? 3'd0 : addr_r;
    assign csr_wdata = send ? s_data : wdata_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_WAIT;
            addr_r     <= 3'd0;
            wr_r       <= 1'b0;
            rd_r       <= 1'b0;
            wdata_r    <= 8'h00;
            burst      <= 5'd0;
            init_done  <= 1'b0;
            bytes_sent <= 32'd0;
        end else begin
            case (state)
                RESET_WAIT: if (start) begin
                    state   <= W_LCR_DLAB;
                    wr_r    <= 1'b1;
                    addr_r  <= 3'd3;
                    wdata_r <= LCR_VAL | 8'h80;
                end
                W_LCR_DLAB: if (!csr_waitreq) begin
                    state   <= W_DLL;
                    addr_r  <= 3'd0;
                    wdata_r <= DIVISOR[7:0];
                end
                W_DLL: if (!csr_waitreq) begin
                    state   <= W_DLM;
                    addr_r  <= 3'd1;
                    wdata_r <= DIVISOR[15:8];
                end
                W_DLM: if (!csr_waitreq) begin
                    state   <= W_LCR;
                    addr_r  <= 3'd3;
                    wdata_r <= LCR_VAL;
                end
                W_LCR: if (!csr_waitreq) begin
                    state   <= W_FCR;
                    addr_r  <= 3'd2;
                    wdata_r <= FCR_VAL;
                end
                W_FCR: if (!csr_waitreq) begin
                    state     <= IDLE;
                    wr_r      <= 1'b0;
                    addr_r    <= 3'd0;
                    wdata_r   <= 8'h00;
                    init_done <= 1'b1;
                end
                IDLE: if (s_valid) begin
                    state  <= POLL;
                    rd_r   <= 1'b1;
                    addr_r <= 3'd5;
                end
                POLL: if (!csr_waitreq) begin
                    state  <= WAIT_RD;
                    rd_r   <= 1'b0;
                    addr_r <= 3'd0;
                end
                WAIT_RD: if (csr_rdvalid) begin
                    state <= csr_rdata[5] ? SEND : IDLE;
                    burst <= csr_rdata[5] ? 5'(TX_BURST) : 5'd0;
                end
                SEND: begin
                    if (hs)
                        bytes_sent <= bytes_sent + 32'd1;
                    // unused credit is dropped so every burst starts from a fresh THRE sample
                    if (!s_valid || (hs && burst == 5'd1)) begin
                        state <= IDLE;
                        burst <= 5'd0;
                    end else if (hs) begin
                        burst <= burst - 5'd1;
                    end
                end
                default: state <= RESET_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_csr_sequencer.sv
// tb_uart_tx_csr_sequencer: directed checks of init sequence, LSR polling, burst pacing and reset recovery
module tb_uart_tx_csr_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [2:0]  csr_addr;
    logic        csr_write;
    logic        csr_read;
    logic [7:0]  csr_wdata;
    logic        csr_waitreq;
    logic [7:0]  csr_rdata;
    logic        csr_rdvalid;
    logic        init_done;
    logic [31:0] bytes_sent;

    uart_tx_csr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .csr_addr(csr_addr), .csr_write(csr_write), .csr_read(csr_read),
        .csr_wdata(csr_wdata), .csr_waitreq(csr_waitreq), .csr_rdata(csr_rdata),
        .csr_rdvalid(csr_rdvalid), .init_done(init_done), .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int rd_cnt = 0;
    int stall = 0;
    int rd_total = 0;
    int rdv_total = 0;
    int both_hi = 0;
    int hold_cnt = 0;
    int early_rdy = 0;
    int done_cyc = -1;
    int first_wr_rdv = -1;
    int tx_idx = 0;
    int tx_n = 0;
    int base;
    int bad;
    logic [7:0] tx_q [64];
    logic [7:0] lsr_q [$];
    logic [2:0] wa [$];
    logic [7:0] wd [$];
    int         wc [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_valid = tx_idx < tx_n;
        s_data  = s_valid ? tx_q[tx_idx] : 8'h00;
    endtask

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        wc.delete();
        rd_total = 0;
        rdv_total = 0;
        hold_cnt = 0;
        early_rdy = 0;
        done_cyc = -1;
        first_wr_rdv = -1;
    endtask

    // one clock: observe bus at negedge, then update producer and CSR slave model after the edge
    task automatic tick();
        logic hs;
        cyc++;
        @(negedge clk);
        if (csr_write && csr_read) both_hi++;
        if (csr_rdvalid) rdv_total++;
        if (csr_write && csr_addr == 3'd0 && csr_wdata == 8'h36 && !init_done) hold_cnt++;
        if (s_ready && rdv_total < 3) early_rdy++;
        if (init_done && done_cyc < 0) done_cyc = cyc;
        if (csr_write && !csr_waitreq) begin
            wa.push_back(csr_addr);
            wd.push_back(csr_wdata);
            wc.push_back(cyc);
            if (init_done && first_wr_rdv < 0) first_wr_rdv = rdv_total;
        end
        if (csr_read && !csr_waitreq) begin
            rd_total++;
            rd_cnt = lat;
        end
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) tx_idx++;
        drive();
        csr_rdvalid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                csr_rdvalid = 1'b1;
                csr_rdata = lsr_q.size() > 0 ? lsr_q.pop_front() : 8'h00;
            end
        end
        csr_waitreq = csr_write && csr_addr == 3'd0 && !init_done && stall > 0;
        if (csr_waitreq) stall--;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_init_log(input string tag);
        logic [2:0] ea [5];
        logic [7:0] ed [5];
        ea = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2};
        ed = '{8'h83, 8'h36, 8'h00, 8'h03, 8'h07};
        check({tag, "_count"}, wa.size(), 5);
        bad = 0;
        for (int i = 0; i < 5 && i < wa.size(); i++)
            if (wa[i] !== ea[i] || wd[i] !== ed[i]) bad++;
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tx_q[i] = 8'(i * 37 + 5);
        rst = 1'b1;
        start = 1'b0;
        csr_waitreq = 1'b0;
        csr_rdata = 8'h00;
        csr_rdvalid = 1'b0;
        drive();
        tick();
        tick();
        check("rst_bus", {csr_write, csr_read, csr_addr, csr_wdata}, 0);
        check("rst_flags", {s_ready, init_done}, 0);
        check("rst_bytes", bytes_sent, 0);
        rst = 1'b0;
        tick();
        check("idle_before_start", {csr_write, csr_read, init_done}, 0);

        // basic init with no stalls
        clear_logs();
        pulse_start();
        for (int i = 0; i < 20 && !init_done; i++) tick();
        tick();
        check_init_log("init");
        bad = 0;
        for (int i = 1; i < wc.size(); i++)
            if (wc[i] != wc[i-1] + 1) bad++;
        check("init_consecutive", bad, 0);
        if (wc.size() == 5) check("init_done_cycle", done_cyc, wc[4] + 1);
        else check("init_done_cycle", done_cyc, 32'hFFFF_FFFF);
        check("init_done_high", init_done, 1);

        // init with a 3-cycle stall on the DLL write
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        stall = 3;
        pulse_start();
        for (int i = 0; i < 30 && !init_done; i++) tick();
        tick();
        check_init_log("stall");
        check("stall_hold_cycles", hold_cnt, 4);
        check("stall_init_done", init_done, 1);

        // 20 bytes, THRE seen each poll, 2-cycle read latency
        clear_logs();
        lsr_q = '{8'h60, 8'h60};
        lat = 2;
        base = tx_n;
        tx_n += 20;
        drive();
        for (int i = 0; i < 300 && tx_idx < tx_n; i++) tick();
        tick();
        tick();
        tick();
        check("burst_writes", wa.size(), 20);
        bad = 0;
        for (int j = 0; j < wa.size(); j++)
            if (wa[j] !== 3'd0 || wd[j] !== tx_q[base + j]) bad++;
        check("burst_data_order", bad, 0);
        check("burst_bytes_sent", bytes_sent, 20);
        check("burst_polls", rd_total, 2);
        if (wc.size() >= 17) check("burst_gap", wc[16] - wc[15] > 1, 1);
        else check("burst_gap", wc.size(), 17);

        // two busy LSR reads before THRE
        clear_logs();
        lsr_q = '{8'h00, 8'h00, 8'h20};
        lat = 1;
        base = tx_n;
        tx_n += 3;
        drive();
        for (int i = 0; i < 200 && tx_idx < tx_n; i++) tick();
        tick();
        tick();
        check("poll_reads", rd_total, 3);
        check("poll_first_write_after", first_wr_rdv, 3);
        check("poll_ready_low", early_rdy, 0);
        check("poll_writes", wa.size(), 3);
        check("poll_bytes_sent", bytes_sent, 23);

        // reset while a read is outstanding, stale rdvalid follows
        clear_logs();
        lsr_q = '{8'h20};
        lat = 3;
        tx_n += 1;
        drive();
        for (int i = 0; i < 20 && rd_total == 0; i++) tick();
        rst = 1'b1;
        #1;
        check("async_rst_done", init_done, 0);
        check("async_rst_bytes", bytes_sent, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("stale_bus", {csr_write, csr_read, csr_addr, csr_wdata}, 0);
        check("stale_flags", {s_ready, init_done}, 0);
        check("stale_no_write", wa.size(), 0);
        check("stale_bytes", bytes_sent, 0);
        tx_idx = tx_n;
        drive();
        lsr_q.delete();

        // re-init, start ignored outside RESET_WAIT, counter wrap
        lat = 1;
        pulse_start();
        for (int i = 0; i < 20 && !init_done; i++) tick();
        tick();
        clear_logs();
        pulse_start();
        tick();
        tick();
        tick();
        check("start_ignored", wa.size(), 0);
        force dut.bytes_sent = 32'hFFFF_FFFF;
        tick();
        release dut.bytes_sent;
        check("wrap_preload", bytes_sent, 32'hFFFF_FFFF);
        lsr_q = '{8'h20};
        base = tx_n;
        tx_n += 1;
        drive();
        for (int i = 0; i < 50 && tx_idx < tx_n; i++) tick();
        tick();
        tick();
        check("wrap_bytes_sent", bytes_sent, 0);
        check("wrap_writes", wa.size(), 1);
        if (wd.size() > 0) check("wrap_data", wd[0], tx_q[base]);
        else check("wrap_data", wd.size(), 1);
        check("never_rd_wr_together", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_csr_sequencer.md
Name: uart_tx_csr_sequencer

Overview:
- Master-side controller that configures a 16550-compatible UART through its CSR window, then drains a byte stream into the transmit holding register (THR).
- Sits between a local byte producer (debug/console logic) and the UART CSR port at BAR 0, feature offset 0x60000.
- Handles baud-divisor/line setup, line-status (LSR) polling and FIFO-burst pacing, so producers see only a valid/ready byte interface.

Parameters:
- DIVISOR, 16'd54, baud divisor written to DLL (low byte) and DLM (high byte).
- LCR_VAL, 8'h03, line control value after setup (8N1); DLAB bit 7 is forced 1 during divisor writes.
- FCR_VAL, 8'h07, FIFO control value (enable, clear RX/TX).
- TX_BURST, 16, bytes written per observed THRE; range 1..16.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins the init sequence; ignored unless state is RESET_WAIT.
- s_data  in  8  byte to transmit.
- s_valid  in  1  byte available.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- csr_addr  out  3  16550 register index (0 THR/DLL, 1 DLM, 2 FCR, 3 LCR, 5 LSR).
- csr_write  out  1  write command.
- csr_read  out  1  read command.
- csr_wdata  out  8  write data.
- csr_waitreq  in  1  slave stall; command and address are held while high.
- csr_rdata  in  8  read data.
- csr_rdvalid  in  1  read data valid.
- init_done  out  1  high once setup is complete.
- bytes_sent  out  32  count of THR writes accepted; wraps at 2^32.

Behaviour:
- Reset values:
  - state = RESET_WAIT.
  - All csr_* outputs = 0.
  - s_ready = 0, init_done = 0, bytes_sent = 0, burst counter = 0.
- A CSR command is accepted on the cycle where (csr_write || csr_read) && !csr_waitreq.
- csr_write and csr_read are never high together.
- At most one read is outstanding; rdata may return with any latency ≥1 cycle after acceptance.
- Init sequence: one write per state, each advancing only on acceptance:
  - W_LCR_DLAB: addr 3, data LCR_VAL|8'h80.
  - W_DLL: addr 0, DIVISOR[7:0].
  - W_DLM: addr 1, DIVISOR[15:8].
  - W_LCR: addr 3, LCR_VAL.
  - W_FCR: addr 2, FCR_VAL.
  - Then IDLE; init_done rises on the cycle IDLE is entered and stays high until reset.
- IDLE: s_ready = 0. If s_valid, go to POLL with csr_read=1, addr 5.
- POLL: hold the read until accepted, then go to WAIT_RD.
- WAIT_RD: on csr_rdvalid:
  - rdata[5]=1 (THRE): load burst counter = TX_BURST, go to SEND.
  - rdata[5]=0: return to IDLE, which re-polls next cycle if s_valid is still high.
- SEND:
  - s_ready = !csr_waitreq && burst>0; csr_write = s_valid; addr 0; csr_wdata = s_data (combinational pass-through).
  - On a handshake: burst decrements and bytes_sent increments.
  - If burst reaches 0, or s_valid is low in a cycle with burst>0, return to IDLE.
  - Remaining burst credit is discarded.
- csr_rdvalid arriving outside WAIT_RD is ignored.
- start pulses after RESET_WAIT are ignored.
- rst asserted mid-transaction: immediate return to reset values. A read left outstanding is dropped, and any later rdvalid is ignored.
- No write of data to THR without a THRE sample since the last IDLE.

Test Plan:
- Reset, start pulse, waitreq=0 → writes (addr,data) in order: (3,83),(0,36),(1,00),(3,03),(2,07) on 5 consecutive cycles; init_done=1 on the next cycle.
- waitreq held high 3 cycles on the W_DLL write → addr 0/data 0x36 held stable for 4 cycles; sequence continues unchanged.
- 20 bytes queued, LSR reads return 0x60 with 2-cycle rdata latency → 16 THR writes, re-poll, 4 writes; bytes_sent=20; data order preserved.
- LSR returns 0x00 twice, then 0x20 → no THR write until the third read; s_ready stays 0 throughout polling.
- rst asserted while WAIT_RD is pending; stale rdvalid arrives 2 cycles later → all outputs at reset values; no write issued; init_done=0.
- bytes_sent preloaded via force to 32'hFFFF_FFFF, one byte sent → bytes_sent=0.
